// File: rtl/twiddle_addr_gen.sv
// Twiddle-factor sequencer for a 1024-point radix-2 DIT FFT: walks every stage/butterfly,
// addresses the twiddle ROM, and streams one twiddle per butterfly. Define TW_CONJ_EN for conjugate output.
module twiddle_addr_gen #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  tw_valid,
    input  logic                  tw_ready,
    output logic [DATA_WIDTH-1:0] tw_data,
    output logic [3:0]            tw_stage,
    output logic [ADDR_WIDTH-1:0] tw_bfly,
    output logic                  tw_last
);

    localparam int HW = DATA_WIDTH / 2;
    localparam logic [3:0]            LAST_STAGE = 4'(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_BFLY  = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // k = (bfly mod 2^stage) << (ADDR_WIDTH - stage); stage 0 gives a zero mask
    function automatic logic [ADDR_WIDTH-1:0] tw_addr(input logic [3:0] stage,
                                                      input logic [ADDR_WIDTH-1:0] bfly);
        logic [ADDR_WIDTH-1:0] mask;
        logic [3:0]            shamt;
        mask  = (ADDR_WIDTH'(1) << stage) - ADDR_WIDTH'(1);
        shamt = LAST_STAGE - stage;
        return (bfly & mask) << shamt;
    endfunction

    // Negate the imaginary half; the most negative value saturates to the most positive
    function automatic logic [DATA_WIDTH-1:0] conj_word(input logic [DATA_WIDTH-1:0] w);
        logic [HW-1:0] im;
        logic [HW-1:0] neg;
        im = w[HW-1:0];
        if (im == {1'b1, {(HW-1){1'b0}}}) begin
            neg = {1'b0, {(HW-1){1'b1}}};
        end else begin
            neg = ~im + HW'(1);
        end
        return {w[DATA_WIDTH-1:HW], neg};
    endfunction

    state_t                state_r, next_state_s;
    logic                  busy_r, done_r, done_s;
    logic                  issue_s, start_ok_s, credit_ok_s, issue_last_s;
    logic [3:0]            stage_r;
    logic [ADDR_WIDTH-1:0] bfly_r;
    logic [ADDR_WIDTH-1:0] rom_addr_r;

    logic                  p0_v_r, p0_last_r, p1_v_r, p1_last_r;
    logic [3:0]            p0_stage_r, p1_stage_r;
    logic [ADDR_WIDTH-1:0] p0_bfly_r, p1_bfly_r;
    logic [2:0]            inflight_s;

    logic [DATA_WIDTH-1:0] fifo_data_r  [0:3];
    logic [3:0]            fifo_stage_r [0:3];
    logic [ADDR_WIDTH-1:0] fifo_bfly_r  [0:3];
    logic                  fifo_last_r  [0:3];
    logic [1:0]            wr_ptr_r, rd_ptr_r;
    logic [2:0]            count_r;
    logic                  push_s, pop_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    assign inflight_s   = {2'b00, p0_v_r} + {2'b00, p1_v_r};
    assign credit_ok_s  = (count_r + inflight_s) < 3'd4;
    assign issue_last_s = (stage_r == LAST_STAGE) && (bfly_r == LAST_BFLY);
    assign push_s       = p1_v_r;
    assign pop_s        = (count_r != 3'd0) && tw_ready;

`ifdef TW_CONJ_EN
    assign wr_data_s = conj_word(rom_data);
`else
    assign wr_data_s = rom_data;
`endif

    // Next-state, issue and completion decode
    always_comb begin
        next_state_s = state_r;
        done_s       = 1'b0;
        issue_s      = 1'b0;
        start_ok_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !done_r) begin
                    next_state_s = ST_RUN;
                    start_ok_s   = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = credit_ok_s;
                if (issue_s && issue_last_s) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_last_r[rd_ptr_r]) begin
                    next_state_s = ST_IDLE;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= done_s;
        end
    end

    // Stage/butterfly counters and ROM address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r    <= 4'd0;
            bfly_r     <= {ADDR_WIDTH{1'b0}};
            rom_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            stage_r <= 4'd0;
            bfly_r  <= {ADDR_WIDTH{1'b0}};
        end else if (issue_s) begin
            rom_addr_r <= tw_addr(stage_r, bfly_r);
            bfly_r     <= bfly_r + ADDR_WIDTH'(1);
            if (bfly_r == LAST_BFLY) begin
                stage_r <= stage_r + 4'd1;
            end
        end
    end

    // Side-band pipeline matching the two-cycle ROM read path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_v_r     <= 1'b0;
            p0_last_r  <= 1'b0;
            p0_stage_r <= 4'd0;
            p0_bfly_r  <= {ADDR_WIDTH{1'b0}};
            p1_v_r     <= 1'b0;
            p1_last_r  <= 1'b0;
            p1_stage_r <= 4'd0;
            p1_bfly_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            p0_v_r     <= issue_s;
            p0_last_r  <= issue_last_s;
            p0_stage_r <= stage_r;
            p0_bfly_r  <= bfly_r;
            p1_v_r     <= p0_v_r;
            p1_last_r  <= p0_last_r;
            p1_stage_r <= p0_stage_r;
            p1_bfly_r  <= p0_bfly_r;
        end
    end

    // Output FIFO; storage is cleared on reset so the head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i]  <= {DATA_WIDTH{1'b0}};
                fifo_stage_r[i] <= 4'd0;
                fifo_bfly_r[i]  <= {ADDR_WIDTH{1'b0}};
                fifo_last_r[i]  <= 1'b0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r]  <= wr_data_s;
                fifo_stage_r[wr_ptr_r] <= p1_stage_r;
                fifo_bfly_r[wr_ptr_r]  <= p1_bfly_r;
                fifo_last_r[wr_ptr_r]  <= p1_last_r;
                wr_ptr_r               <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rom_addr = rom_addr_r;
    assign tw_valid = (count_r != 3'd0);
    assign tw_data  = fifo_data_r[rd_ptr_r];
    assign tw_stage = fifo_stage_r[rd_ptr_r];
    assign tw_bfly  = fifo_bfly_r[rd_ptr_r];
    assign tw_last  = fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Scoreboard bench for twiddle_addr_gen: expected words queued at start, popped by a monitor.
module tb_twiddle_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, tw_valid, tw_last;
    logic        tw_ready = 1'b0;
    logic [8:0]  rom_addr, tw_bfly;
    logic [47:0] rom_data, tw_data;
    logic [3:0]  tw_stage;

    int total = 0;
    int bad = 0;
    int sweep_pops = 0;

    typedef struct {
        logic [3:0]  stage;
        logic [8:0]  bfly;
        logic        last;
        logic [47:0] data;
    } exp_t;
    exp_t exp_q[$];

    int dir_stage[7] = '{1, 9, 8, 0, 9, 2, 3};
    int dir_bfly [7] = '{3, 5, 255, 17, 511, 6, 5};
    int dir_addr [7] = '{256, 5, 510, 0, 511, 256, 320};

    twiddle_addr_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .tw_valid(tw_valid),
        .tw_ready(tw_ready), .tw_data(tw_data), .tw_stage(tw_stage),
        .tw_bfly(tw_bfly), .tw_last(tw_last)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rom_fn(input logic [8:0] a);
        if (a == 9'd0) return {24'h400000, 24'h800000};
        if (a == 9'd1) return {24'h7FFFFF, 24'h000010};
        return {3'b010, a, 12'h5A3, 3'b101, a, 12'h0C3};
    endfunction

    function automatic logic [47:0] exp_data(input logic [8:0] a);
        logic [47:0] w;
        w = rom_fn(a);
`ifdef TW_CONJ_EN
        if (a == 9'd0) return {24'h400000, 24'h7FFFFF};
        if (a == 9'd1) return {24'h7FFFFF, 24'hFFFFF0};
        w[23:0] = 24'd0 - w[23:0];
`endif
        return w;
    endfunction

    function automatic logic [8:0] model_addr(input int s, input int b);
        int k;
        if (s == 0) return 9'd0;
        k = (b % (1 << s)) * (1 << (9 - s));
        return 9'(k % 512);
    endfunction

    // Registered ROM model
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_sweep();
        exp_t e;
        for (int s = 0; s < 10; s++) begin
            for (int b = 0; b < 512; b++) begin
                e.stage = 4'(s);
                e.bfly  = 9'(b);
                e.last  = (s == 9) && (b == 511);
                e.data  = exp_data(model_addr(s, b));
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: compares popped words, hold-while-stalled and the done pulse
    logic        prev_stall = 1'b0;
    logic        prev_last_pop = 1'b0;
    logic [47:0] hold_data;
    logic [3:0]  hold_stage;
    logic [8:0]  hold_bfly;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall    = 1'b0;
            prev_last_pop = 1'b0;
        end else begin
            chk("done_pulse", 64'(done), 64'(prev_last_pop));
            if (prev_stall) begin
                chk("hold_valid", 64'(tw_valid), 64'd1);
                chk("hold_data", 64'(tw_data), 64'(hold_data));
                chk("hold_tag", 64'({tw_stage, tw_bfly}), 64'({hold_stage, hold_bfly}));
            end
            if (tw_valid && tw_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got stage %0d bfly %0d expected none", tw_stage, tw_bfly);
                end else begin
                    e = exp_q.pop_front();
                    chk("stage", 64'(tw_stage), 64'(e.stage));
                    chk("bfly", 64'(tw_bfly), 64'(e.bfly));
                    chk("last", 64'(tw_last), 64'(e.last));
                    chk("data", 64'(tw_data), 64'(e.data));
                    for (int i = 0; i < 7; i++) begin
                        if (int'(tw_stage) == dir_stage[i] && int'(tw_bfly) == dir_bfly[i])
                            chk("dir_addr", 64'(tw_data), 64'(exp_data(9'(dir_addr[i]))));
                    end
                end
                sweep_pops++;
            end
            prev_stall    = tw_valid && !tw_ready;
            hold_data     = tw_data;
            hold_stage    = tw_stage;
            hold_bfly     = tw_bfly;
            prev_last_pop = tw_valid && tw_ready && tw_last;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_valid"}, 64'(tw_valid), 64'd0);
        chk({tag, "_last"}, 64'(tw_last), 64'd0);
        chk({tag, "_addr"}, 64'(rom_addr), 64'd0);
        chk({tag, "_data"}, 64'(tw_data), 64'd0);
        chk({tag, "_stage"}, 64'(tw_stage), 64'd0);
        chk({tag, "_bfly"}, 64'(tw_bfly), 64'd0);
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        push_sweep();
        sweep_pops = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget, input bit random_ready);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
            else if (random_ready) tw_ready = 1'($urandom_range(0, 1));
        end
        chk("done_seen", 64'(seen), 64'd1);
        tw_ready = 1'b1;
        // start in the done cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_done_ignored", 64'({busy, tw_valid}), 64'd0);
        chk("transfers", 64'(sweep_pops), 64'd5120);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tw_ready = 1'b1;

        // Sweep 1: free running, with first-word latency and a start pulse during RUN
        do_start();
        chk("valid_e0", 64'(tw_valid), 64'd0);
        @(posedge clk); #1;
        chk("addr_e1", 64'(rom_addr), 64'd0);
        chk("valid_e1", 64'(tw_valid), 64'd0);
        @(posedge clk); #1;
        chk("valid_e2", 64'(tw_valid), 64'd0);
        @(posedge clk); #1;
        chk("valid_e3", 64'(tw_valid), 64'd1);
        chk("first_tag", 64'({tw_stage, tw_bfly}), 64'd0);
        repeat (100) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6000, 1'b0);

        // Sweep 2: random backpressure
        do_start();
        wait_done(20000, 1'b1);

        // Sweep 3: abort at transfer 1000, then a clean replay
        do_start();
        for (int i = 0; i < 3000 && sweep_pops < 1000; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_1000", 64'(sweep_pops >= 1000), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_abort", 64'({busy, done}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_abort", 64'({busy, tw_valid}), 64'd0);
        do_start();
        wait_done(6000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
